// File: rtl/j_result_deserializer.sv
// j_result_deserializer: rebuilds LSB-first serial lane results into words
// and drains the per-lane holding registers round-robin onto one stream.
module j_result_deserializer #(
    parameter int SUBARRAY_HEIGHT = 1,
    parameter int ACC_WIDTH       = 16,
    parameter int W_LANE          = (4 * SUBARRAY_HEIGHT > 1) ?
                                    $clog2(4 * SUBARRAY_HEIGHT) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [4*SUBARRAY_HEIGHT-1:0] result,
    input  logic [4*SUBARRAY_HEIGHT-1:0] result_en,
    input  logic [4*SUBARRAY_HEIGHT-1:0] result_start,
    input  logic [4*SUBARRAY_HEIGHT-1:0] result_end,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic [W_LANE-1:0]            out_lane,
    output logic                         out_trunc,
    output logic                         overflow_err,
    output logic                         protocol_err
);
    localparam int L  = 4 * SUBARRAY_HEIGHT;
    localparam int CW = $clog2(ACC_WIDTH + 1);
    localparam logic [CW-1:0]        C_ONE = CW'(1);
    localparam logic [CW-1:0]        C_MAX = CW'(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] W_ONE = ACC_WIDTH'(1);

    typedef enum logic {IDLE, ACTIVE} lane_st_t;

    lane_st_t             st_q  [L];
    lane_st_t             st_d  [L];
    logic [ACC_WIDTH-1:0] sh_q  [L];
    logic [ACC_WIDTH-1:0] sh_d  [L];
    logic [CW-1:0]        cnt_q [L];
    logic [CW-1:0]        cnt_d [L];
    logic                 tr_q  [L];
    logic                 tr_d  [L];
    logic [ACC_WIDTH-1:0] cmp_w [L];
    logic                 cmp_t [L];
    logic [ACC_WIDTH-1:0] hold_w[L];
    logic                 hold_t[L];

    logic [L-1:0]      fin;
    logic [L-1:0]      perr_hit;
    logic [L-1:0]      cmp_v;
    logic [L-1:0]      hold_v;
    logic [L-1:0]      drain;
    logic              load;
    logic              found;
    logic [W_LANE-1:0] gnt;
    logic [W_LANE-1:0] rr_ptr;
    logic [W_LANE-1:0] rr_nxt;
    int                idx;
    int                nxt;

    // Bits above n were cleared at start, so OR-ing the mask extends the sign.
    function automatic logic [ACC_WIDTH-1:0] sext(
        input logic [ACC_WIDTH-1:0] w,
        input logic [CW-1:0]        n
    );
        logic [ACC_WIDTH-1:0] hi;
        hi   = ~((W_ONE << n) - W_ONE);
        sext = (|(w & (W_ONE << (n - C_ONE)))) ? (w | hi) : w;
    endfunction

    always_comb begin
        fin      = '0;
        perr_hit = '0;
        for (int i = 0; i < L; i++) begin
            st_d[i]  = st_q[i];
            sh_d[i]  = sh_q[i];
            cnt_d[i] = cnt_q[i];
            tr_d[i]  = tr_q[i];
            if (result_en[i]) begin
                if (result_start[i]) begin
                    perr_hit[i] = (st_q[i] == ACTIVE);
                    sh_d[i]     = ACC_WIDTH'(result[i]);
                    cnt_d[i]    = C_ONE;
                    tr_d[i]     = 1'b0;
                    st_d[i]     = result_end[i] ? IDLE : ACTIVE;
                    fin[i]      = result_end[i];
                end else if (st_q[i] == ACTIVE) begin
                    if (cnt_q[i] < C_MAX) begin
                        sh_d[i]  = sh_q[i] |
                                   (ACC_WIDTH'(result[i]) << cnt_q[i]);
                        cnt_d[i] = cnt_q[i] + C_ONE;
                    end else begin
                        tr_d[i] = 1'b1;
                    end
                    st_d[i] = result_end[i] ? IDLE : ACTIVE;
                    fin[i]  = result_end[i];
                end else begin
                    perr_hit[i] = result_end[i];
                end
            end
        end
    end

    assign load = !out_valid || out_ready;

    always_comb begin
        found  = 1'b0;
        gnt    = '0;
        idx    = 0;
        nxt    = 0;
        drain  = '0;
        for (int k = 0; k < L; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= L) idx = idx - L;
            if (!found && hold_v[W_LANE'(idx)]) begin
                found = 1'b1;
                gnt   = W_LANE'(idx);
            end
        end
        nxt = int'(gnt) + 1;
        if (nxt >= L) nxt = 0;
        rr_nxt = W_LANE'(nxt);
        if (load && found) drain[gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < L; i++) begin
                st_q[i]   <= IDLE;
                sh_q[i]   <= '0;
                cnt_q[i]  <= '0;
                tr_q[i]   <= 1'b0;
                cmp_w[i]  <= '0;
                cmp_t[i]  <= 1'b0;
                hold_w[i] <= '0;
                hold_t[i] <= 1'b0;
            end
            cmp_v        <= '0;
            hold_v       <= '0;
            overflow_err <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            for (int i = 0; i < L; i++) begin
                st_q[i]  <= st_d[i];
                sh_q[i]  <= sh_d[i];
                cnt_q[i] <= cnt_d[i];
                tr_q[i]  <= tr_d[i];
                cmp_w[i] <= sext(sh_d[i], cnt_d[i]);
                cmp_t[i] <= tr_d[i];
                if (cmp_v[i]) begin
                    if (!hold_v[i] || drain[i]) begin
                        hold_v[i] <= 1'b1;
                        hold_w[i] <= cmp_w[i];
                        hold_t[i] <= cmp_t[i];
                    end else begin
                        overflow_err <= 1'b1;
                    end
                end else if (drain[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
            cmp_v <= fin;
            if (|perr_hit) protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_trunc <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data  <= hold_w[gnt];
                out_lane  <= gnt;
                out_trunc <= hold_t[gnt];
                rr_ptr    <= rr_nxt;
            end
        end
    end

endmodule

// File: doc/j_result_deserializer.md
Name: j_result_deserializer

Overview:
- Sits directly downstream of the systolic subarray and consumes its per-row bit-serial outputs: 4 lanes per row, framed by result, result_en, result_start and result_end.
- Each lane's LSB-first two's-complement bit stream is reassembled into a parallel ACC_WIDTH word.
- Completed words are buffered in per-lane holding registers.
- A round-robin arbiter drains the holding registers onto a single valid/ready output stream, tagged with the lane index.

Parameters:
- SUBARRAY_HEIGHT, 1, rows of the feeding array; lane count L = 4*SUBARRAY_HEIGHT.
- ACC_WIDTH, 16, width of the reassembled word.
- W_LANE, clog2(4*SUBARRAY_HEIGHT) (minimum 1), width of the lane index.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- result  in  L  serial data bit per lane.
- result_en  in  L  lane bit valid this cycle.
- result_start  in  L  marks the LSB (first bit) of a word; qualified by result_en.
- result_end  in  L  marks the MSB (last bit) of a word; qualified by result_en.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  ACC_WIDTH  reassembled, sign-extended word.
- out_lane  out  W_LANE  source lane of out_data.
- out_trunc  out  1  word had more than ACC_WIDTH bits; upper bits were dropped.
- overflow_err  out  1  sticky: a word was dropped because its holding register was full.
- protocol_err  out  1  sticky: end without start, or start during an open word.

Behaviour:
- Reset: asynchronous assert while reset=0. All outputs, shift registers, bit counters, holding flags, round-robin pointer and sticky errors go to 0. Reset mid-word discards all partial and held words.
- Bit sampling: result_start and result_end are ignored when result_en=0.
- Per-lane assembly FSM, states IDLE and ACTIVE:
  - IDLE, en&start: clear shift register, store the bit at position 0, count=1. Go to ACTIVE, or COMPLETE in the same cycle if end is also set (1-bit word).
  - IDLE, en&end&!start: protocol_err<=1, bit ignored.
  - IDLE, en only: bit ignored.
  - ACTIVE, en&!start: store the bit at position count if count<ACC_WIDTH, otherwise set the lane trunc flag. count saturates at ACC_WIDTH. If end is also set, COMPLETE and return to IDLE.
  - ACTIVE, en&start: protocol_err<=1, discard the partial word, restart exactly as from IDLE.
- COMPLETE:
  - The word is sign-extended from bit count-1 to ACC_WIDTH. If trunc is set, bits are taken as stored.
  - Word and trunc flag load into the lane holding register, hold_v<=1, on the edge after the end bit is sampled.
  - If hold_v=1 and the holding register is not being drained that same cycle: the word is dropped, overflow_err<=1, hold_v is unchanged.
  - If the holding register is drained in the same cycle: the new word is accepted and there is no error.
- Arbiter:
  - The output register loads when !out_valid or (out_valid&out_ready).
  - Candidate is the first lane with hold_v=1, searching from rr_ptr upward with wrap-around at L-1 -> 0.
  - On load: out_data, out_lane and out_trunc take the candidate's values; that lane's hold_v clears; rr_ptr <= granted+1 mod L.
  - If there is no candidate at a load opportunity, out_valid<=0.
- Latency: end bit at edge T, holding at T+1, out_valid at T+2 when the output stage is idle.
- Throughput: one word per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_lane and out_trunc stay stable.
- Multiple lanes: all lanes operate concurrently and independently; simultaneous completions are fine.
- Sticky errors: clear only on reset.

Test Plan:
- Sign extension: ACC_WIDTH=8, lane 0, bits 1,0,1,1,1 (start on first, end on last), out_ready=1 -> out_data=0xFD, out_lane=0, out_trunc=0, out_valid exactly 2 cycles after the end bit.
- Truncation: ACC_WIDTH=8, lane 2, 10-bit word 0x155 -> out_data=0x55, out_trunc=1, no errors.
- Round-robin: H=1, lanes 0..3 end in the same cycle with values 1, 2, 3, 4, out_ready=1 -> outputs lanes 0,1,2,3 on consecutive cycles. Then lanes 0 and 3 both pending with rr_ptr=1 -> lane 3 granted first.
- Backpressure and overflow: out_ready=0, lane 1 completes three words -> first held in the output register, second in holding, third dropped with overflow_err=1. Raise out_ready -> exactly two words emerge, in order.
- Protocol errors: end without start on lane 0 -> protocol_err=1, no output. Start during an open word -> partial discarded, new word (e.g. 0x07) emitted correctly.
- Reset mid-word: assert reset after 3 bits -> all outputs 0 immediately. After release, a fresh 4-bit word 0x5 -> out_data=0x05.
